// File: rtl/i2c_reg_responder.sv
// I2C register target: oversampled SCL/SDA, 7-bit address, sub-address pointer,
// burst writes and combined-format reads against an external 8-bit register file.
//   state  | meaning
//   IDLE   | bus free, SDA released, waiting for START
//   DEVADR | shifting device address + R/W, ACK on match
//   SUBADR | shifting register pointer, ACK
//   WRDATA | shifting write bytes, ACK + write strobe, burst capable
//   RDDATA | shifting register bytes out, sampling master ACK/NACK
//   IGNORE | not addressed or NACKed, waiting for START/STOP
module i2c_reg_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         FILT_LEN = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] oREG_ADDR,
  output logic [7:0] oREG_WDATA,
  output logic       oREG_WE,
  input  logic [7:0] iREG_RDATA,
  output logic       oBUSY
);

  localparam logic [2:0] FILT_TC = 3'(FILT_LEN - 1);

  typedef enum logic [2:0] {IDLE, DEVADR, SUBADR, WRDATA, RDDATA, IGNORE} state_t;

  logic [1:0] sclSync, sdaSync;
  logic [2:0] sclCnt, sdaCnt;
  logic       sclFilt, sdaFilt, sclPrev, sdaPrev;
  logic       sclRise, sclFall, startDet, stopDet;

  state_t     state, stateNext;
  logic [3:0] bitCnt, bitCntNext;
  logic [7:0] shReg, shRegNext, addrNext, wdataNext;
  logic       sdaOe, sdaOeNext, weNext, busyNext;

  // Run-length filter: a line only moves after FILT_LEN consecutive differing samples
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sclSync <= 2'b11;
      sdaSync <= 2'b11;
      sclFilt <= 1'b1;
      sdaFilt <= 1'b1;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
      sclCnt  <= FILT_TC;
      sdaCnt  <= FILT_TC;
    end else begin
      sclSync <= {sclSync[0], I2C_SCLK};
      sdaSync <= {sdaSync[0], I2C_SDAT};
      sclPrev <= sclFilt;
      sdaPrev <= sdaFilt;
      if (sclSync[1] == sclFilt) begin
        sclCnt <= FILT_TC;
      end else if (sclCnt == 3'd0) begin
        sclFilt <= sclSync[1];
        sclCnt  <= FILT_TC;
      end else begin
        sclCnt <= sclCnt - 3'd1;
      end
      if (sdaSync[1] == sdaFilt) begin
        sdaCnt <= FILT_TC;
      end else if (sdaCnt == 3'd0) begin
        sdaFilt <= sdaSync[1];
        sdaCnt  <= FILT_TC;
      end else begin
        sdaCnt <= sdaCnt - 3'd1;
      end
    end
  end

  assign sclRise  = sclFilt & ~sclPrev;
  assign sclFall  = ~sclFilt & sclPrev;
  assign startDet = sdaPrev & ~sdaFilt & sclFilt & sclPrev;
  assign stopDet  = ~sdaPrev & sdaFilt & sclFilt & sclPrev;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      bitCnt     <= 4'd0;
      shReg      <= 8'h00;
      sdaOe      <= 1'b0;
      oREG_ADDR  <= 8'h00;
      oREG_WDATA <= 8'h00;
      oREG_WE    <= 1'b0;
      oBUSY      <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      shReg      <= shRegNext;
      sdaOe      <= sdaOeNext;
      oREG_ADDR  <= addrNext;
      oREG_WDATA <= wdataNext;
      oREG_WE    <= weNext;
      oBUSY      <= busyNext;
    end
  end

  // bitCnt 8 = byte complete (ACK slot next), 9 = ACK clock has risen
  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    shRegNext  = shReg;
    sdaOeNext  = sdaOe;
    addrNext   = oREG_WE ? oREG_ADDR + 8'd1 : oREG_ADDR;
    wdataNext  = oREG_WDATA;
    weNext     = 1'b0;
    busyNext   = oBUSY;
    if (stopDet) begin
      stateNext = IDLE;
      sdaOeNext = 1'b0;
      busyNext  = 1'b0;
    end else if (startDet) begin
      stateNext  = DEVADR;
      bitCntNext = 4'd0;
      sdaOeNext  = 1'b0;
      busyNext   = 1'b0;
    end else begin
      case (state)
        DEVADR, SUBADR, WRDATA: begin
          if (sclRise) begin
            if (bitCnt < 4'd8) begin
              shRegNext  = {shReg[6:0], sdaFilt};
              bitCntNext = bitCnt + 4'd1;
            end else begin
              bitCntNext = 4'd9;
            end
          end else if (sclFall && bitCnt == 4'd8) begin
            sdaOeNext = 1'b1;
            if (state == DEVADR) begin
              if (shReg[7:1] != DEV_ADDR) begin
                stateNext = IGNORE;
                sdaOeNext = 1'b0;
              end else begin
                busyNext = 1'b1;
              end
            end else if (state == SUBADR) begin
              addrNext = shReg;
            end else begin
              wdataNext = shReg;
              weNext    = 1'b1;
            end
          end else if (sclFall && bitCnt == 4'd9) begin
            sdaOeNext  = 1'b0;
            bitCntNext = 4'd0;
            if (state == DEVADR && shReg[0]) begin
              stateNext = RDDATA;
              shRegNext = iREG_RDATA;
              sdaOeNext = ~iREG_RDATA[7];
              addrNext  = oREG_ADDR + 8'd1;
            end else if (state == DEVADR) begin
              stateNext = SUBADR;
            end else begin
              stateNext = WRDATA;
            end
          end
        end
        RDDATA: begin
          if (sclRise) begin
            if (bitCnt < 4'd8) begin
              bitCntNext = bitCnt + 4'd1;
            end else if (sdaFilt) begin
              stateNext = IGNORE;
              busyNext  = 1'b0;
            end else begin
              bitCntNext = 4'd9;
            end
          end else if (sclFall) begin
            if (bitCnt == 4'd8) begin
              sdaOeNext = 1'b0;
            end else if (bitCnt == 4'd9) begin
              shRegNext  = iREG_RDATA;
              sdaOeNext  = ~iREG_RDATA[7];
              addrNext   = oREG_ADDR + 8'd1;
              bitCntNext = 4'd0;
            end else if (bitCnt != 4'd0) begin
              shRegNext = {shReg[6:0], 1'b0};
              sdaOeNext = ~shReg[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign I2C_SDAT = sdaOe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Directed + randomized bench: bit-level I2C master, register-file stub, and a
// transaction-level model of expected write strobes, read bytes and pointer.
module tb_i2c_reg_responder;

  localparam int Q = 8;
  localparam int H = 16;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       scl = 1'b1;
  logic       mLow = 1'b0;
  wire        sda;
  logic [7:0] oREG_ADDR, oREG_WDATA, iREG_RDATA;
  logic       oREG_WE, oBUSY;

  assign sda = mLow ? 1'b0 : 1'bz;
  pullup (sda);

  assign iREG_RDATA = oREG_ADDR ^ 8'h5A;

  i2c_reg_responder dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .I2C_SCLK(scl), .I2C_SDAT(sda),
    .oREG_ADDR(oREG_ADDR), .oREG_WDATA(oREG_WDATA), .oREG_WE(oREG_WE),
    .iREG_RDATA(iREG_RDATA), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] weLog[$];
  logic [15:0] expWe[$];
  logic [7:0]  modelPtr = 8'h00;
  logic [7:0]  txBuf[8];
  logic        dutLowSeen = 1'b0;
  logic        busySeen = 1'b0;

  always @(negedge iCLK) begin
    if (oREG_WE) weLog.push_back({oREG_ADDR, oREG_WDATA});
    if (!mLow && sda === 1'b0) dutLowSeen = 1'b1;
    if (oBUSY) busySeen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic bitClock(input logic drv, input logic glitch, output logic smp);
    waitClk(Q); mLow = ~drv;
    waitClk(Q); scl = 1'b1;
    waitClk(H/4);
    if (glitch) begin
      mLow = 1'b1; waitClk(1); mLow = ~drv;
    end
    waitClk(H/4); smp = sda;
    waitClk(H/2); scl = 1'b0;
  endtask

  task automatic i2cStart();
    waitClk(Q); mLow = 1'b0;
    waitClk(Q); scl = 1'b1;
    waitClk(H/2); mLow = 1'b1;
    waitClk(H/2); scl = 1'b0;
  endtask

  task automatic i2cStop();
    waitClk(Q); mLow = 1'b1;
    waitClk(Q); scl = 1'b1;
    waitClk(H/2); mLow = 1'b0;
    waitClk(H);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bitClock(b[i], 1'b0, d);
    bitClock(1'b1, 1'b0, ack);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bitClock(1'b1, 1'b0, d);
      b[i] = d;
    end
    bitClock(nack, 1'b0, d);
  endtask

  task automatic compareWe(input string tag);
    check({tag, "_we_count"}, weLog.size(), expWe.size());
    for (int i = 0; i < expWe.size() && i < weLog.size(); i++)
      check({tag, "_we"}, weLog[i], expWe[i]);
    weLog.delete();
    expWe.delete();
  endtask

  task automatic doWrite(input logic [7:0] sub, input int len, input string tag);
    logic ack;
    i2cStart();
    writeByte(8'h72, ack);
    check({tag, "_dev_ack"}, ack, 1'b0);
    check({tag, "_busy"}, oBUSY, 1'b1);
    writeByte(sub, ack);
    check({tag, "_sub_ack"}, ack, 1'b0);
    for (int i = 0; i < len; i++) begin
      writeByte(txBuf[i], ack);
      check({tag, "_data_ack"}, ack, 1'b0);
      expWe.push_back({8'(sub + i), txBuf[i]});
    end
    modelPtr = 8'(sub + len);
    i2cStop();
    compareWe(tag);
    check({tag, "_ptr"}, oREG_ADDR, modelPtr);
    check({tag, "_busy_after"}, oBUSY, 1'b0);
  endtask

  task automatic doRead(input logic [7:0] sub, input int len, input string tag);
    logic       ack;
    logic [7:0] b;
    i2cStart();
    writeByte(8'h72, ack);
    check({tag, "_dev_ack"}, ack, 1'b0);
    writeByte(sub, ack);
    check({tag, "_sub_ack"}, ack, 1'b0);
    i2cStart();
    writeByte(8'h73, ack);
    check({tag, "_rd_ack"}, ack, 1'b0);
    check({tag, "_busy"}, oBUSY, 1'b1);
    for (int i = 0; i < len; i++) begin
      readByte(i == len - 1, b);
      check({tag, "_rdata"}, b, 8'(sub + i) ^ 8'h5A);
    end
    check({tag, "_sda_released"}, sda, 1'b1);
    modelPtr = 8'(sub + len);
    i2cStop();
    compareWe(tag);
    check({tag, "_ptr"}, oREG_ADDR, modelPtr);
    check({tag, "_busy_after"}, oBUSY, 1'b0);
  endtask

  initial begin
    logic       ack, d;
    logic [7:0] sub;
    int         len;

    waitClk(3);
    check("rst_addr", oREG_ADDR, 8'h00);
    check("rst_sda", sda, 1'b1);
    iRST_N = 1'b1;
    waitClk(10);
    check("idle_addr", oREG_ADDR, 8'h00);
    check("idle_wdata", oREG_WDATA, 8'h00);
    check("idle_we", oREG_WE, 1'b0);
    check("idle_busy", oBUSY, 1'b0);

    txBuf[0] = 8'hAB;
    doWrite(8'h10, 1, "wr_single");

    txBuf[0] = 8'h01; txBuf[1] = 8'h02; txBuf[2] = 8'h03;
    doWrite(8'hFE, 3, "wr_burst_wrap");

    doRead(8'h20, 2, "rd_combined");

    dutLowSeen = 1'b0;
    busySeen = 1'b0;
    i2cStart();
    writeByte(8'h74, ack);
    check("bad_dev_nack", ack, 1'b1);
    writeByte(8'h10, ack);
    check("bad_sub_nack", ack, 1'b1);
    writeByte(8'hAB, ack);
    check("bad_data_nack", ack, 1'b1);
    i2cStop();
    check("bad_no_drive", dutLowSeen, 1'b0);
    check("bad_no_busy", busySeen, 1'b0);
    compareWe("bad_addr");
    check("bad_ptr", oREG_ADDR, modelPtr);
    txBuf[0] = 8'h66;
    doWrite(8'h55, 1, "wr_after_bad");

    // glitch inside a complete byte, then STOP part-way through the next byte
    i2cStart();
    writeByte(8'h72, ack);
    check("gl_dev_ack", ack, 1'b0);
    writeByte(8'h40, ack);
    check("gl_sub_ack", ack, 1'b0);
    bitClock(1'b1, 1'b1, d);
    for (int i = 6; i >= 0; i--) bitClock(((8'hC3 >> i) & 8'h01) != 8'h00, 1'b0, d);
    bitClock(1'b1, 1'b0, ack);
    check("gl_data_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) bitClock(1'b1, 1'b0, d);
    i2cStop();
    expWe.push_back({8'h40, 8'hC3});
    modelPtr = 8'h41;
    compareWe("glitch_stop");
    check("gl_ptr", oREG_ADDR, modelPtr);
    check("gl_busy", oBUSY, 1'b0);

    // reset while the address ACK is being driven
    i2cStart();
    for (int i = 7; i >= 0; i--) bitClock(((8'h72 >> i) & 8'h01) != 8'h00, 1'b0, d);
    waitClk(Q); mLow = 1'b0;
    waitClk(Q); scl = 1'b1;
    waitClk(H/2);
    check("rst_ack_driven", sda, 1'b0);
    #2 iRST_N = 1'b0;
    #1;
    check("rst_mid_sda", sda, 1'b1);
    check("rst_mid_addr", oREG_ADDR, 8'h00);
    check("rst_mid_wdata", oREG_WDATA, 8'h00);
    check("rst_mid_we", oREG_WE, 1'b0);
    check("rst_mid_busy", oBUSY, 1'b0);
    waitClk(2);
    iRST_N = 1'b1;
    waitClk(H/2);
    scl = 1'b0;
    i2cStop();
    modelPtr = 8'h00;
    compareWe("rst_recover");
    txBuf[0] = 8'h5C;
    doWrite(8'h33, 1, "wr_after_rst");

    repeat (8) begin
      sub = 8'($urandom);
      len = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < len; i++) txBuf[i] = 8'($urandom);
        doWrite(sub, len, "rand_wr");
      end else begin
        doRead(sub, len, "rand_rd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
